unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
Moore FSM that sequences fluxo_dados for the sequence-memory game. Each round it replays ROM positions 0..sequencia on db_memoria, timed by the TMR counter, then collects and checks player moves. The round grows by one until the full 16-entry sequence is matched, a wrong move occurs, or the move timeout fires. It sits between the top level (iniciar, status LEDs, 7-seg state display) and fluxo_dados (all zera/registra/conta strobes).

Parameters:
USA_TIMEOUT, 1, when 0 the timeout input is ignored and ESPERA never exits on timeout.

Ports:
clock  in  1  system clock (1 kHz board clock)
reset  in  1  synchronous active-high reset
iniciar  in  1  start/restart request, level-sampled
jogada_feita  in  1  one-cycle pulse from the edge detector
chavesIgualMemoria  in  1  registered move equals ROM data
enderecoIgualSequencia  in  1  address counter equals sequence counter
fimS  in  1  sequence counter at 15
fimTMR  in  1  display-interval counter at terminal count
timeout  in  1  move timeout reached
zeraR, zeraE, zeraS, zeraM, zeraTMR  out  1 each  clears to datapath
registraR, registraM  out  1 each  register loads
contaE, contaS, contaTMR  out  1 each  counter enables
pronto  out  1  game over, any outcome
acertou  out  1  full sequence matched
errou  out  1  wrong move or timeout
db_timeout  out  1  game ended by timeout
db_estado  out  4  current state code, driven to the 7-seg display

Behaviour:
- Moore machine: all outputs are decoded from the state register only. Any output not listed for a state is 0.
- Reset: synchronous and active-high. When reset=1 at a clock edge, state becomes INICIAL, all outputs are 0 and db_estado=0. Reset mid-game is honoured from any state.
- State codes and behaviour:
  - INICIAL=0: no outputs. Goes to PREPARACAO when iniciar=1.
  - PREPARACAO=1: zeraS, zeraE, zeraR, zeraM, zeraTMR. Goes to INICIA_RODADA.
  - INICIA_RODADA=2: zeraE, zeraTMR. Goes to MOSTRA.
  - MOSTRA=3: registraM, contaTMR. Stays until fimTMR=1, then goes to APAGA.
  - APAGA=4: zeraM, contaTMR. Stays until fimTMR=1. Then goes to INICIA_JOGADAS if enderecoIgualSequencia=1, else PROXIMO_MOSTRA.
  - PROXIMO_MOSTRA=5: contaE. Goes to MOSTRA.
  - INICIA_JOGADAS=6: zeraE, zeraR. Goes to ESPERA.
  - ESPERA=7: no outputs.
    - jogada_feita=1 goes to REGISTRA.
    - Otherwise, timeout=1 with USA_TIMEOUT=1 goes to FIM_TIMEOUT.
    - Otherwise stays.
    - If both arrive in the same cycle, jogada_feita wins.
  - REGISTRA=8: registraR. Goes to COMPARA.
  - COMPARA=9:
    - chavesIgualMemoria=0 goes to FIM_ERRO.
    - Otherwise enderecoIgualSequencia=1 goes to ULTIMA_RODADA.
    - Otherwise goes to PROXIMA_JOGADA.
  - PROXIMA_JOGADA=A: contaE. Goes to ESPERA.
  - ULTIMA_RODADA=B: fimS=1 goes to FIM_ACERTO, else goes to PROXIMA_RODADA.
  - PROXIMA_RODADA=F: contaS. Goes to INICIA_RODADA.
  - FIM_ACERTO=C: pronto, acertou.
  - FIM_TIMEOUT=D: pronto, errou, db_timeout.
  - FIM_ERRO=E: pronto, errou.
  - All three terminal states hold while iniciar=0 and go to PREPARACAO when iniciar=1.
- iniciar is ignored in every non-terminal state except INICIAL.
- The TMR counter wraps to 0 on fimTMR while contaTMR=1, so back-to-back MOSTRA/APAGA intervals need no extra clear. MOSTRA and APAGA each last exactly M_TMR cycles.
- One cycle of ROM latency is absorbed: registraM stays high for the whole of MOSTRA.
- Round k (sequencia=k) shows k+1 values and then accepts k+1 moves.
- Unused codes: none; all 16 codes are assigned.

Decomposition:
- Package `jogo_pkg` holds the 4-bit localparam state codes listed above; the top level and bench reuse them for db_estado decoding.
- No sub-module: state register, next-state logic and output decode stay in one module. The 7-seg decoder lives outside.

Test Plan:
- Reset with iniciar held at 0: db_estado=0, all strobes 0, pronto=0, every cycle.
- iniciar=1, then fimTMR pulsed every 5 cycles, enderecoIgualSequencia=1 at first APAGA exit: sequence of states is 1,2,3,4,6,7. registraM is high for the 5 MOSTRA cycles and zeraM for the 5 APAGA cycles.
- In ESPERA, pulse jogada_feita with chavesIgualMemoria=1, enderecoIgualSequencia=1, fimS=0: states are 8,9,B,F,2, with contaS high for exactly one cycle.
- Same, but with chavesIgualMemoria=0: states are 8,9,E. Then pronto=1, errou=1, acertou=0, held for 100 cycles. iniciar=1 then returns to state 1.
- ESPERA with timeout=1 and jogada_feita=0: next state D, pronto=errou=db_timeout=1. Repeat with USA_TIMEOUT=0: stays in 7. Repeat with timeout and jogada_feita in the same cycle: goes to 8.
- Full win, with fimS=1 at the last ULTIMA_RODADA: C, with acertou=1. Assert reset while in MOSTRA: next cycle db_estado=0, all outputs 0.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game controller: state codes,
// the state enum and the control-strobe bundle with its per-state decode.
package jogo_pkg;

    localparam int unsigned EST_W = 4;

    localparam logic [EST_W-1:0] COD_INICIAL        = 4'h0;
    localparam logic [EST_W-1:0] COD_PREPARACAO     = 4'h1;
    localparam logic [EST_W-1:0] COD_INICIA_RODADA  = 4'h2;
    localparam logic [EST_W-1:0] COD_MOSTRA         = 4'h3;
    localparam logic [EST_W-1:0] COD_APAGA          = 4'h4;
    localparam logic [EST_W-1:0] COD_PROXIMO_MOSTRA = 4'h5;
    localparam logic [EST_W-1:0] COD_INICIA_JOGADAS = 4'h6;
    localparam logic [EST_W-1:0] COD_ESPERA         = 4'h7;
    localparam logic [EST_W-1:0] COD_REGISTRA       = 4'h8;
    localparam logic [EST_W-1:0] COD_COMPARA        = 4'h9;
    localparam logic [EST_W-1:0] COD_PROXIMA_JOGADA = 4'hA;
    localparam logic [EST_W-1:0] COD_ULTIMA_RODADA  = 4'hB;
    localparam logic [EST_W-1:0] COD_FIM_ACERTO     = 4'hC;
    localparam logic [EST_W-1:0] COD_FIM_TIMEOUT    = 4'hD;
    localparam logic [EST_W-1:0] COD_FIM_ERRO       = 4'hE;
    localparam logic [EST_W-1:0] COD_PROXIMA_RODADA = 4'hF;

    typedef enum logic [EST_W-1:0] {
        INICIAL        = COD_INICIAL,
        PREPARACAO     = COD_PREPARACAO,
        INICIA_RODADA  = COD_INICIA_RODADA,
        MOSTRA         = COD_MOSTRA,
        APAGA          = COD_APAGA,
        PROXIMO_MOSTRA = COD_PROXIMO_MOSTRA,
        INICIA_JOGADAS = COD_INICIA_JOGADAS,
        ESPERA         = COD_ESPERA,
        REGISTRA       = COD_REGISTRA,
        COMPARA        = COD_COMPARA,
        PROXIMA_JOGADA = COD_PROXIMA_JOGADA,
        ULTIMA_RODADA  = COD_ULTIMA_RODADA,
        FIM_ACERTO     = COD_FIM_ACERTO,
        FIM_TIMEOUT    = COD_FIM_TIMEOUT,
        FIM_ERRO       = COD_FIM_ERRO,
        PROXIMA_RODADA = COD_PROXIMA_RODADA
    } estado_t;

    typedef struct packed {
        logic zera_r;
        logic zera_e;
        logic zera_s;
        logic zera_m;
        logic zera_tmr;
        logic registra_r;
        logic registra_m;
        logic conta_e;
        logic conta_s;
        logic conta_tmr;
        logic pronto;
        logic acertou;
        logic errou;
        logic db_timeout;
    } controle_t;

    // Moore decode: strobes asserted while sitting in a given state
    function automatic controle_t decodifica(input estado_t e);
        controle_t c;
        c = '0;
        case (e)
            PREPARACAO: begin
                c.zera_s   = 1'b1;
                c.zera_e   = 1'b1;
                c.zera_r   = 1'b1;
                c.zera_m   = 1'b1;
                c.zera_tmr = 1'b1;
            end
            INICIA_RODADA: begin
                c.zera_e   = 1'b1;
                c.zera_tmr = 1'b1;
            end
            MOSTRA: begin
                c.registra_m = 1'b1;
                c.conta_tmr  = 1'b1;
            end
            APAGA: begin
                c.zera_m    = 1'b1;
                c.conta_tmr = 1'b1;
            end
            PROXIMO_MOSTRA: c.conta_e = 1'b1;
            INICIA_JOGADAS: begin
                c.zera_e = 1'b1;
                c.zera_r = 1'b1;
            end
            REGISTRA:       c.registra_r = 1'b1;
            PROXIMA_JOGADA: c.conta_e    = 1'b1;
            PROXIMA_RODADA: c.conta_s    = 1'b1;
            FIM_ACERTO: begin
                c.pronto  = 1'b1;
                c.acertou = 1'b1;
            end
            FIM_TIMEOUT: begin
                c.pronto     = 1'b1;
                c.errou      = 1'b1;
                c.db_timeout = 1'b1;
            end
            FIM_ERRO: begin
                c.pronto = 1'b1;
                c.errou  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore controller for the sequence-memory game: replays the ROM sequence,
// then collects and checks player moves round by round.
module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter bit USA_TIMEOUT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             jogada_feita,
    input  logic             chavesIgualMemoria,
    input  logic             enderecoIgualSequencia,
    input  logic             fimS,
    input  logic             fimTMR,
    input  logic             timeout,
    output logic             zeraR,
    output logic             zeraE,
    output logic             zeraS,
    output logic             zeraM,
    output logic             zeraTMR,
    output logic             registraR,
    output logic             registraM,
    output logic             contaE,
    output logic             contaS,
    output logic             contaTMR,
    output logic             pronto,
    output logic             acertou,
    output logic             errou,
    output logic             db_timeout,
    output logic [EST_W-1:0] db_estado
);

    estado_t   estado;
    estado_t   prox;
    controle_t ctl;
    controle_t ctl_prox;

    // Outputs are registered from the decode of the next state, so they
    // line up with the state register exactly as a Moore decode would.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
            ctl    <= '0;
        end else begin
            estado <= prox;
            ctl    <= ctl_prox;
        end
    end

    always_comb begin
        prox     = estado;
        ctl_prox = '0;
        case (estado)
            INICIAL:        if (iniciar) prox = PREPARACAO;
            PREPARACAO:     prox = INICIA_RODADA;
            INICIA_RODADA:  prox = MOSTRA;
            MOSTRA:         if (fimTMR) prox = APAGA;
            APAGA: begin
                if (fimTMR) prox = enderecoIgualSequencia ? INICIA_JOGADAS : PROXIMO_MOSTRA;
            end
            PROXIMO_MOSTRA: prox = MOSTRA;
            INICIA_JOGADAS: prox = ESPERA;
            ESPERA: begin
                // A move arriving with the timeout still counts as a move
                if (jogada_feita)                  prox = REGISTRA;
                else if (timeout && USA_TIMEOUT)   prox = FIM_TIMEOUT;
            end
            REGISTRA:       prox = COMPARA;
            COMPARA: begin
                if (!chavesIgualMemoria)          prox = FIM_ERRO;
                else if (enderecoIgualSequencia)  prox = ULTIMA_RODADA;
                else                              prox = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: prox = ESPERA;
            ULTIMA_RODADA:  prox = fimS ? FIM_ACERTO : PROXIMA_RODADA;
            PROXIMA_RODADA: prox = INICIA_RODADA;
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: begin
                if (iniciar) prox = PREPARACAO;
            end
            default:        prox = INICIAL;
        endcase
        ctl_prox = decodifica(prox);
    end

    assign zeraR      = ctl.zera_r;
    assign zeraE      = ctl.zera_e;
    assign zeraS      = ctl.zera_s;
    assign zeraM      = ctl.zera_m;
    assign zeraTMR    = ctl.zera_tmr;
    assign registraR  = ctl.registra_r;
    assign registraM  = ctl.registra_m;
    assign contaE     = ctl.conta_e;
    assign contaS     = ctl.conta_s;
    assign contaTMR   = ctl.conta_tmr;
    assign pronto     = ctl.pronto;
    assign acertou    = ctl.acertou;
    assign errou      = ctl.errou;
    assign db_timeout = ctl.db_timeout;
    assign db_estado  = EST_W'(estado);

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Scripted scenarios for the game controller; each applied step queues its
// expected state, which is popped and compared once the clock edge has landed.
module tb_unidade_controle_jogo;
    import jogo_pkg::*;

    logic clock = 1'b0;
    logic reset, iniciar, jogada_feita, chaves, end_igual, fim_s, fim_tmr, timeout;

    wire [13:0] saidas;
    wire [13:0] saidas_n;
    wire [3:0]  db_estado;
    wire [3:0]  db_estado_n;

    localparam int B_ZR = 13, B_ZE = 12, B_ZS = 11, B_ZM = 10, B_ZT = 9;
    localparam int B_RR = 8, B_RM = 7, B_CE = 6, B_CS = 5, B_CT = 4;
    localparam int B_PR = 3, B_AC = 2, B_ER = 1, B_TO = 0;

    typedef struct {
        string      tag;
        logic [3:0] est;
        logic [3:0] est_nt;
    } item_t;

    item_t fila[$];
    int    n_vet = 0;
    int    n_err = 0;

    always #5 clock = ~clock;

    unidade_controle_jogo #(.USA_TIMEOUT(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .chavesIgualMemoria(chaves), .enderecoIgualSequencia(end_igual), .fimS(fim_s),
        .fimTMR(fim_tmr), .timeout(timeout),
        .zeraR(saidas[B_ZR]), .zeraE(saidas[B_ZE]), .zeraS(saidas[B_ZS]), .zeraM(saidas[B_ZM]),
        .zeraTMR(saidas[B_ZT]), .registraR(saidas[B_RR]), .registraM(saidas[B_RM]),
        .contaE(saidas[B_CE]), .contaS(saidas[B_CS]), .contaTMR(saidas[B_CT]),
        .pronto(saidas[B_PR]), .acertou(saidas[B_AC]), .errou(saidas[B_ER]),
        .db_timeout(saidas[B_TO]), .db_estado(db_estado)
    );

    unidade_controle_jogo #(.USA_TIMEOUT(1'b0)) dut_nt (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .chavesIgualMemoria(chaves), .enderecoIgualSequencia(end_igual), .fimS(fim_s),
        .fimTMR(fim_tmr), .timeout(timeout),
        .zeraR(saidas_n[B_ZR]), .zeraE(saidas_n[B_ZE]), .zeraS(saidas_n[B_ZS]), .zeraM(saidas_n[B_ZM]),
        .zeraTMR(saidas_n[B_ZT]), .registraR(saidas_n[B_RR]), .registraM(saidas_n[B_RM]),
        .contaE(saidas_n[B_CE]), .contaS(saidas_n[B_CS]), .contaTMR(saidas_n[B_CT]),
        .pronto(saidas_n[B_PR]), .acertou(saidas_n[B_AC]), .errou(saidas_n[B_ER]),
        .db_timeout(saidas_n[B_TO]), .db_estado(db_estado_n)
    );

    // Expected strobes per state code, straight from the state table
    function automatic logic [13:0] esperado(input logic [3:0] s);
        logic [13:0] v;
        v = '0;
        case (s)
            COD_PREPARACAO:     begin v[B_ZS] = 1; v[B_ZE] = 1; v[B_ZR] = 1; v[B_ZM] = 1; v[B_ZT] = 1; end
            COD_INICIA_RODADA:  begin v[B_ZE] = 1; v[B_ZT] = 1; end
            COD_MOSTRA:         begin v[B_RM] = 1; v[B_CT] = 1; end
            COD_APAGA:          begin v[B_ZM] = 1; v[B_CT] = 1; end
            COD_PROXIMO_MOSTRA: v[B_CE] = 1;
            COD_INICIA_JOGADAS: begin v[B_ZE] = 1; v[B_ZR] = 1; end
            COD_REGISTRA:       v[B_RR] = 1;
            COD_PROXIMA_JOGADA: v[B_CE] = 1;
            COD_PROXIMA_RODADA: v[B_CS] = 1;
            COD_FIM_ACERTO:     begin v[B_PR] = 1; v[B_AC] = 1; end
            COD_FIM_TIMEOUT:    begin v[B_PR] = 1; v[B_ER] = 1; v[B_TO] = 1; end
            COD_FIM_ERRO:       begin v[B_PR] = 1; v[B_ER] = 1; end
            default:            v = '0;
        endcase
        return v;
    endfunction

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vet++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic limpa();
        iniciar = 0; jogada_feita = 0; chaves = 0; end_igual = 0;
        fim_s = 0; fim_tmr = 0; timeout = 0;
    endtask

    // Apply the current inputs for one edge; expectations go through the queue
    task automatic passo2(input string tag, input logic [3:0] est, input logic [3:0] est_nt);
        item_t it;
        fila.push_back('{tag, est, est_nt});
        @(posedge clock);
        #1;
        if (fila.size() == 0) begin
            verifica({tag, "/queue_empty"}, 32'd0, 32'd1);
        end else begin
            it = fila.pop_front();
            verifica({it.tag, "/estado"}, 32'(db_estado), 32'(it.est));
            verifica({it.tag, "/saidas"}, 32'(saidas), 32'(esperado(it.est)));
            verifica({it.tag, "/estado_nt"}, 32'(db_estado_n), 32'(it.est_nt));
        end
    endtask

    task automatic passo(input string tag, input logic [3:0] est);
        passo2(tag, est, est);
    endtask

    // From first MOSTRA cycle: 5 cycles MOSTRA, 5 cycles APAGA, then exit
    task automatic mostra_apaga(input logic eq);
        for (int i = 0; i < 4; i++) passo("mostra", COD_MOSTRA);
        fim_tmr = 1; passo("mostra_fim", COD_APAGA); fim_tmr = 0;
        for (int i = 0; i < 4; i++) passo("apaga", COD_APAGA);
        fim_tmr = 1; end_igual = eq;
        passo("apaga_fim", eq ? COD_INICIA_JOGADAS : COD_PROXIMO_MOSTRA);
        fim_tmr = 0; end_igual = 0;
    endtask

    task automatic ate_espera();
        passo("prep", COD_INICIA_RODADA);
        passo("ini_rod", COD_MOSTRA);
        mostra_apaga(1'b1);
        passo("ini_jog", COD_ESPERA);
    endtask

    initial begin
        limpa();
        reset = 1;
        for (int i = 0; i < 3; i++) passo("reset", COD_INICIAL);
        reset = 0;
        passo("idle", COD_INICIAL);
        iniciar = 1; passo("iniciar", COD_PREPARACAO); iniciar = 0;
        ate_espera();

        // round 0 succeeds, round grows
        passo("espera", COD_ESPERA);
        iniciar = 1; passo("espera_ign_ini", COD_ESPERA); iniciar = 0;
        jogada_feita = 1; passo("jogada", COD_REGISTRA); jogada_feita = 0;
        passo("registra", COD_COMPARA);
        chaves = 1; end_igual = 1; passo("compara_ok", COD_ULTIMA_RODADA);
        chaves = 0; end_igual = 0;
        fim_s = 0; passo("ultima", COD_PROXIMA_RODADA);
        passo("prox_rod", COD_INICIA_RODADA);
        passo("ini_rod2", COD_MOSTRA);

        // round 1: two values shown, two moves, second wrong
        mostra_apaga(1'b0);
        passo("prox_mostra", COD_MOSTRA);
        mostra_apaga(1'b1);
        passo("ini_jog2", COD_ESPERA);
        jogada_feita = 1; passo("jogada2", COD_REGISTRA); jogada_feita = 0;
        passo("registra2", COD_COMPARA);
        chaves = 1; end_igual = 0; passo("compara_mid", COD_PROXIMA_JOGADA); chaves = 0;
        passo("prox_jog", COD_ESPERA);
        jogada_feita = 1; passo("jogada3", COD_REGISTRA); jogada_feita = 0;
        passo("registra3", COD_COMPARA);
        chaves = 0; end_igual = 1; passo("compara_err", COD_FIM_ERRO); end_igual = 0;
        for (int i = 0; i < 100; i++) passo("fim_erro_hold", COD_FIM_ERRO);
        iniciar = 1; passo("restart_err", COD_PREPARACAO); iniciar = 0;
        ate_espera();

        // timeout: honoured only when enabled
        timeout = 1; passo2("timeout", COD_FIM_TIMEOUT, COD_ESPERA); timeout = 0;
        passo2("timeout_hold", COD_FIM_TIMEOUT, COD_ESPERA);
        iniciar = 1; passo2("restart_to", COD_PREPARACAO, COD_ESPERA); iniciar = 0;
        reset = 1; passo("reset_resync", COD_INICIAL); reset = 0;
        iniciar = 1; passo("iniciar2", COD_PREPARACAO); iniciar = 0;
        ate_espera();

        // simultaneous move and timeout, then win on last round
        timeout = 1; jogada_feita = 1; passo("jogada_vs_to", COD_REGISTRA);
        timeout = 0; jogada_feita = 0;
        passo("registra4", COD_COMPARA);
        chaves = 1; end_igual = 1; passo("compara_ok2", COD_ULTIMA_RODADA);
        chaves = 0; end_igual = 0;
        fim_s = 1; passo("ultima_fim", COD_FIM_ACERTO); fim_s = 0;
        for (int i = 0; i < 5; i++) passo("acerto_hold", COD_FIM_ACERTO);
        iniciar = 1; passo("restart_win", COD_PREPARACAO); iniciar = 0;
        passo("prep2", COD_INICIA_RODADA);
        passo("ini_rod3", COD_MOSTRA);
        passo("mostra2", COD_MOSTRA);
        reset = 1; passo("reset_mostra", COD_INICIAL); reset = 0;
        passo("idle2", COD_INICIAL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_err);
        $finish;
    end

endmodule
